// File: rtl/de_pipe_pkg.sv
// de_pipe_pkg: shared ID/EX control word type, bubble value and field encodings.
// Used by the decode stage and by decode_execute_register.
package de_pipe_pkg;
  typedef enum logic [1:0] {FW_NONE = 2'b00, FW_NZ = 2'b01, FW_CV = 2'b10, FW_ALL = 2'b11} flag_write_e;
  typedef enum logic [1:0] {MD_WORD = 2'b00, MD_HALF = 2'b01, MD_BYTE = 2'b10, MD_VEC = 2'b11} mem_data_e;
  typedef struct packed {
    logic       pc_src;
    logic       reg_write;
    logic       reg_write_v;
    logic       mem_to_reg;
    logic       mem_write;
    logic [2:0] alu_control;
    logic       alu_sel;
    logic       branch;
    logic       alu_src;
    logic       mem_src;
    logic [1:0] flag_write;
    logic [1:0] mem_data;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
  function automatic logic has_side_effect(ctrl_t c);
    return c.pc_src | c.reg_write | c.reg_write_v | c.mem_write | c.branch | (|c.flag_write);
  endfunction
endpackage

// File: rtl/decode_execute_register_if.sv
// decode_execute_register_if: ID/EX stage bus.
// Decode side: stall_e, flush_e, valid_d, ctrl_d, rd1_d, rd2_d, vd1_d, vd2_d, imm_d, wa_d.
// Execute side: valid_e, ctrl_e, rd1_e, rd2_e, vd1_e, vd2_e, imm_e, wa_e.
// master drives the decode side and observes the execute side; slave is the register.
interface decode_execute_register_if
  import de_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int VEC_W  = 128,
  parameter int RA_W   = 5
);
  logic              stall_e, flush_e, valid_d, valid_e;
  ctrl_t             ctrl_d, ctrl_e;
  logic [DATA_W-1:0] rd1_d, rd2_d, imm_d, rd1_e, rd2_e, imm_e;
  logic [VEC_W-1:0]  vd1_d, vd2_d, vd1_e, vd2_e;
  logic [RA_W-1:0]   wa_d, wa_e;
  modport master (
    output stall_e, flush_e, valid_d, ctrl_d, rd1_d, rd2_d, vd1_d, vd2_d, imm_d, wa_d,
    input  valid_e, ctrl_e, rd1_e, rd2_e, vd1_e, vd2_e, imm_e, wa_e
  );
  modport slave (
    input  stall_e, flush_e, valid_d, ctrl_d, rd1_d, rd2_d, vd1_d, vd2_d, imm_d, wa_d,
    output valid_e, ctrl_e, rd1_e, rd2_e, vd1_e, vd2_e, imm_e, wa_e
  );
endinterface

// File: rtl/de_pipe_field.sv
// de_pipe_field: one pipeline register group with sync active-low reset, stall hold and flush.
// Ports: clk, rst_n, stall (hold), flush (load CLR), clr (load CLR instead of d), d, q.
// Reset and flush both load CLR; clr only matters on a normal load.
module de_pipe_field #(
  parameter int           W   = 8,
  parameter logic [W-1:0] CLR = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         flush,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (!rst_n || flush) q <= CLR;
    else if (!stall) q <= clr ? CLR : d;
endmodule

// File: rtl/decode_execute_register.sv
// decode_execute_register: ID/EX pipeline register of the SIMD AES core.
// Ports: clk, rst_n (sync, active low), bus (decode_execute_register_if.slave),
//        stat_instr/stat_bubble/stat_stall (only when DE_REG_STATS_EN is defined).
// Priority per edge: reset > flush > stall > load. A load with valid_d=0 carries a
// NOP control word so a bubble can never write state downstream.
// Optional feature macro: DE_REG_STATS_EN (saturating instruction/bubble/stall counters).
module decode_execute_register
  import de_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int VEC_W  = 128,
  parameter int RA_W   = 5
`ifdef DE_REG_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic clk,
  input  logic rst_n,
`ifdef DE_REG_STATS_EN
  output logic [CNT_W-1:0] stat_instr,
  output logic [CNT_W-1:0] stat_bubble,
  output logic [CNT_W-1:0] stat_stall,
`endif
  decode_execute_register_if.slave bus
);
  logic                valid_q;
  ctrl_t               ctrl_q;
  logic [3*DATA_W-1:0] scalar_q;
  logic [2*VEC_W-1:0]  vector_q;
  logic [RA_W-1:0]     addr_q;
  always_ff @(posedge clk)
    if (!rst_n || bus.flush_e) valid_q <= 1'b0;
    else if (!bus.stall_e) valid_q <= bus.valid_d;
  de_pipe_field #(.W($bits(ctrl_t)), .CLR(CTRL_NOP)) u_ctrl (
    .clk(clk), .rst_n(rst_n), .stall(bus.stall_e), .flush(bus.flush_e),
    .clr(!bus.valid_d), .d(bus.ctrl_d), .q(ctrl_q)
  );
  de_pipe_field #(.W(3*DATA_W)) u_scalar (
    .clk(clk), .rst_n(rst_n), .stall(bus.stall_e), .flush(bus.flush_e),
    .clr(1'b0), .d({bus.rd1_d, bus.rd2_d, bus.imm_d}), .q(scalar_q)
  );
  de_pipe_field #(.W(2*VEC_W)) u_vector (
    .clk(clk), .rst_n(rst_n), .stall(bus.stall_e), .flush(bus.flush_e),
    .clr(1'b0), .d({bus.vd1_d, bus.vd2_d}), .q(vector_q)
  );
  de_pipe_field #(.W(RA_W)) u_addr (
    .clk(clk), .rst_n(rst_n), .stall(bus.stall_e), .flush(bus.flush_e),
    .clr(1'b0), .d(bus.wa_d), .q(addr_q)
  );
  assign bus.valid_e = valid_q;
  assign bus.ctrl_e  = ctrl_q;
  assign {bus.rd1_e, bus.rd2_e, bus.imm_e} = scalar_q;
  assign {bus.vd1_e, bus.vd2_e} = vector_q;
  assign bus.wa_e = addr_q;
`ifdef DE_REG_STATS_EN
  logic load, bubble, held;
  assign load   = !bus.flush_e && !bus.stall_e;
  assign bubble = bus.flush_e || (load && !bus.valid_d);
  assign held   = bus.stall_e && !bus.flush_e;
  always_ff @(posedge clk)
    if (!rst_n) begin
      stat_instr  <= '0;
      stat_bubble <= '0;
      stat_stall  <= '0;
    end else begin
      if (load && bus.valid_d && !(&stat_instr)) stat_instr <= stat_instr + 1'b1;
      if (bubble && !(&stat_bubble)) stat_bubble <= stat_bubble + 1'b1;
      if (held && !(&stat_stall)) stat_stall <= stat_stall + 1'b1;
    end
`endif
endmodule

// File: tb/tb_decode_execute_register.sv
// tb_decode_execute_register: self-checking bench for decode_execute_register.
module tb_decode_execute_register;
  import de_pipe_pkg::*;
  localparam int DATA_W = 32;
  localparam int VEC_W  = 128;
  localparam int RA_W   = 5;
`ifdef DE_REG_STATS_EN
  localparam int CNT_W = 4;
  localparam int SMAX  = (1 << CNT_W) - 1;
  logic [CNT_W-1:0] stat_instr, stat_bubble, stat_stall;
  int m_si, m_sb, m_ss;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  bit started = 1'b0;
  always #5 clk = ~clk;
  decode_execute_register_if #(.DATA_W(DATA_W), .VEC_W(VEC_W), .RA_W(RA_W)) bus ();
  decode_execute_register #(
    .DATA_W(DATA_W), .VEC_W(VEC_W), .RA_W(RA_W)
`ifdef DE_REG_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef DE_REG_STATS_EN
    .stat_instr(stat_instr),
    .stat_bubble(stat_bubble),
    .stat_stall(stat_stall),
`endif
    .bus(bus)
  );
  logic              m_v;
  ctrl_t             m_c;
  logic [DATA_W-1:0] m_rd1, m_rd2, m_imm;
  logic [VEC_W-1:0]  m_vd1, m_vd2;
  logic [RA_W-1:0]   m_wa;
  always @(negedge clk)
    if (started && bus.valid_e === 1'b0) begin
      total++;
      if ({bus.ctrl_e.pc_src, bus.ctrl_e.reg_write, bus.ctrl_e.reg_write_v, bus.ctrl_e.mem_write,
           bus.ctrl_e.branch, bus.ctrl_e.flag_write} !== 7'b0) begin
        bad++;
        $display("FAIL invariant: valid_e=0 but ctrl_e=%h", bus.ctrl_e);
      end
    end
  task automatic model_clear();
    m_v = 1'b0; m_c = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_vd1 = '0; m_vd2 = '0; m_wa = '0;
  endtask
  task automatic tick();
    if (!rst_n) begin
      model_clear();
`ifdef DE_REG_STATS_EN
      m_si = 0; m_sb = 0; m_ss = 0;
`endif
    end else if (bus.flush_e) begin
      model_clear();
`ifdef DE_REG_STATS_EN
      if (m_sb < SMAX) m_sb++;
`endif
    end else if (bus.stall_e) begin
`ifdef DE_REG_STATS_EN
      if (m_ss < SMAX) m_ss++;
`endif
    end else begin
      m_v = bus.valid_d;
      m_c = bus.valid_d ? bus.ctrl_d : CTRL_NOP;
      m_rd1 = bus.rd1_d; m_rd2 = bus.rd2_d; m_imm = bus.imm_d;
      m_vd1 = bus.vd1_d; m_vd2 = bus.vd2_d; m_wa = bus.wa_d;
`ifdef DE_REG_STATS_EN
      if (bus.valid_d && m_si < SMAX) m_si++;
      if (!bus.valid_d && m_sb < SMAX) m_sb++;
`endif
    end
    @(posedge clk);
    #1;
  endtask
  task automatic rand_in();
    logic [15:0] r;
    r = 16'($urandom);
    bus.ctrl_d = r;
    bus.rd1_d = $urandom; bus.rd2_d = $urandom; bus.imm_d = $urandom;
    bus.vd1_d = {$urandom, $urandom, $urandom, $urandom};
    bus.vd2_d = {$urandom, $urandom, $urandom, $urandom};
    bus.wa_d = 5'($urandom);
  endtask
  task automatic test_reset();
    rst_n = 1'b1; bus.stall_e = 1'b0; bus.flush_e = 1'b0; bus.valid_d = 1'b1;
    bus.ctrl_d = '1; bus.rd1_d = '1; bus.rd2_d = '1; bus.imm_d = '1;
    bus.vd1_d = '1; bus.vd2_d = '1; bus.wa_d = '1;
    tick();
    rst_n = 1'b0; bus.stall_e = 1'b1; bus.flush_e = 1'b1;
    tick();
    started = 1'b1;
    total++;
    if (bus.valid_e !== 1'b0) begin bad++; $display("FAIL reset valid_e: got %b want 0", bus.valid_e); end
    total++;
    if (bus.ctrl_e !== 16'h0) begin bad++; $display("FAIL reset ctrl_e: got %h want 0", bus.ctrl_e); end
    total++;
    if (bus.rd1_e !== 32'h0) begin bad++; $display("FAIL reset rd1_e: got %h want 0", bus.rd1_e); end
    total++;
    if (bus.vd1_e !== 128'h0) begin bad++; $display("FAIL reset vd1_e: got %h want 0", bus.vd1_e); end
    total++;
    if ({bus.rd2_e, bus.imm_e, bus.vd2_e, bus.wa_e} !== '0) begin
      bad++; $display("FAIL reset other data: got %h want 0", {bus.rd2_e, bus.imm_e, bus.vd2_e, bus.wa_e});
    end
    rst_n = 1'b1; bus.stall_e = 1'b0; bus.flush_e = 1'b0;
  endtask
  task automatic test_load();
    ctrl_t c;
    c = CTRL_NOP; c.reg_write = 1'b1;
    bus.valid_d = 1'b1; bus.ctrl_d = c; bus.rd1_d = 32'hDEAD_BEEF; bus.wa_d = 5'd7;
    #1;
    total++;
    if (bus.rd1_e !== 32'h0) begin bad++; $display("FAIL load early rd1_e: got %h want 0", bus.rd1_e); end
    tick();
    total++;
    if (bus.valid_e !== 1'b1) begin bad++; $display("FAIL load valid_e: got %b want 1", bus.valid_e); end
    total++;
    if (bus.rd1_e !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load rd1_e: got %h want deadbeef", bus.rd1_e); end
    total++;
    if (bus.wa_e !== 5'd7) begin bad++; $display("FAIL load wa_e: got %0d want 7", bus.wa_e); end
    total++;
    if (bus.ctrl_e.reg_write !== 1'b1) begin bad++; $display("FAIL load reg_write: got %b want 1", bus.ctrl_e.reg_write); end
  endtask
  task automatic test_stall();
    logic [VEC_W-1:0] held;
    held = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    bus.valid_d = 1'b1; bus.vd1_d = held;
    tick();
    bus.stall_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.vd1_d = {$urandom, $urandom, $urandom, ~held[31:0]};
      tick();
      total++;
      if (bus.vd1_e !== held) begin bad++; $display("FAIL stall vd1_e cycle %0d: got %h want %h", i, bus.vd1_e, held); end
    end
    bus.stall_e = 1'b0;
    tick();
    total++;
    if (bus.vd1_e !== bus.vd1_d) begin bad++; $display("FAIL stall release vd1_e: got %h want %h", bus.vd1_e, bus.vd1_d); end
  endtask
  task automatic test_flush_stall();
    ctrl_t c;
    c = CTRL_NOP; c.mem_write = 1'b1;
    bus.valid_d = 1'b1; bus.ctrl_d = c; bus.rd1_d = 32'h1234_5678;
    tick();
    total++;
    if ({bus.valid_e, bus.ctrl_e.mem_write} !== 2'b11) begin
      bad++; $display("FAIL pre-flush valid/mem_write: got %b want 11", {bus.valid_e, bus.ctrl_e.mem_write});
    end
    bus.flush_e = 1'b1; bus.stall_e = 1'b1;
    tick();
    total++;
    if (bus.valid_e !== 1'b0) begin bad++; $display("FAIL flush valid_e: got %b want 0", bus.valid_e); end
    total++;
    if (bus.ctrl_e !== CTRL_NOP) begin bad++; $display("FAIL flush ctrl_e: got %h want 0", bus.ctrl_e); end
    total++;
    if (bus.rd1_e !== 32'h0) begin bad++; $display("FAIL flush rd1_e: got %h want 0", bus.rd1_e); end
    bus.flush_e = 1'b0;
    tick();
    total++;
    if ({bus.valid_e, bus.ctrl_e, bus.rd1_e} !== '0) begin
      bad++; $display("FAIL stalled bubble: got valid=%b ctrl=%h rd1=%h want 0", bus.valid_e, bus.ctrl_e, bus.rd1_e);
    end
    bus.stall_e = 1'b0;
  endtask
  task automatic test_invalid_load();
    bus.valid_d = 1'b0; bus.ctrl_d = '1; bus.rd1_d = 32'hCAFE_F00D; bus.wa_d = 5'd19;
    tick();
    total++;
    if (bus.ctrl_e.mem_write !== 1'b0) begin bad++; $display("FAIL invalid mem_write: got %b want 0", bus.ctrl_e.mem_write); end
    total++;
    if (bus.valid_e !== 1'b0) begin bad++; $display("FAIL invalid valid_e: got %b want 0", bus.valid_e); end
    total++;
    if (bus.ctrl_e !== CTRL_NOP) begin bad++; $display("FAIL invalid ctrl_e: got %h want 0", bus.ctrl_e); end
    total++;
    if ({bus.rd1_e, bus.wa_e} !== {32'hCAFE_F00D, 5'd19}) begin
      bad++; $display("FAIL invalid data: got rd1=%h wa=%0d want cafef00d/19", bus.rd1_e, bus.wa_e);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n = $urandom_range(0, 99) >= 3;
      bus.flush_e = $urandom_range(0, 99) < 12;
      bus.stall_e = $urandom_range(0, 99) < 25;
      bus.valid_d = $urandom_range(0, 99) < 70;
      rand_in();
      tick();
      total++;
      if ({bus.valid_e, bus.ctrl_e, bus.rd1_e, bus.rd2_e, bus.imm_e, bus.vd1_e, bus.vd2_e, bus.wa_e} !==
          {m_v, m_c, m_rd1, m_rd2, m_imm, m_vd1, m_vd2, m_wa}) begin
        bad++;
        $display("FAIL random step %0d: got %h want %h", i,
          {bus.valid_e, bus.ctrl_e, bus.rd1_e, bus.rd2_e, bus.imm_e, bus.vd1_e, bus.vd2_e, bus.wa_e},
          {m_v, m_c, m_rd1, m_rd2, m_imm, m_vd1, m_vd2, m_wa});
      end
`ifdef DE_REG_STATS_EN
      total++;
      if ({stat_instr, stat_bubble, stat_stall} !== {CNT_W'(m_si), CNT_W'(m_sb), CNT_W'(m_ss)}) begin
        bad++;
        $display("FAIL random stats step %0d: got %0d/%0d/%0d want %0d/%0d/%0d", i,
          stat_instr, stat_bubble, stat_stall, m_si, m_sb, m_ss);
      end
`endif
    end
    rst_n = 1'b1; bus.flush_e = 1'b0; bus.stall_e = 1'b0;
  endtask
`ifdef DE_REG_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; bus.flush_e = 1'b0; bus.stall_e = 1'b0; bus.valid_d = 1'b1;
    for (int i = 0; i < 4; i++) begin rand_in(); tick(); end
    bus.stall_e = 1'b1;
    tick(); tick();
    bus.stall_e = 1'b0; bus.flush_e = 1'b1;
    tick();
    bus.flush_e = 1'b0;
    total++;
    if (stat_instr !== 4'd4) begin bad++; $display("FAIL stats instr: got %0d want 4", stat_instr); end
    total++;
    if (stat_stall !== 4'd2) begin bad++; $display("FAIL stats stall: got %0d want 2", stat_stall); end
    total++;
    if (stat_bubble !== 4'd1) begin bad++; $display("FAIL stats bubble: got %0d want 1", stat_bubble); end
    for (int i = 0; i < 20; i++) begin rand_in(); tick(); end
    total++;
    if (stat_instr !== 4'hF) begin bad++; $display("FAIL stats saturate: got %0d want 15", stat_instr); end
  endtask
`endif
  initial begin
    bus.stall_e = 1'b0; bus.flush_e = 1'b0; bus.valid_d = 1'b0; bus.ctrl_d = '0;
    bus.rd1_d = '0; bus.rd2_d = '0; bus.imm_d = '0; bus.vd1_d = '0; bus.vd2_d = '0; bus.wa_d = '0;
    model_clear();
`ifdef DE_REG_STATS_EN
    m_si = 0; m_sb = 0; m_ss = 0;
`endif
    @(posedge clk);
    #1;
    test_reset();
    test_load();
    test_stall();
    test_flush_stall();
    test_invalid_load();
    test_random();
`ifdef DE_REG_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
